// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB full-speed receive front end.
//   rx_state_t : receive FSM states
//   LINE_J     : line level that represents J (idle)
//   BYTE_W     : assembled byte width
package usb_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_EOP,
    RX_WAIT
  } rx_state_t;

  localparam logic LINE_J = 1'b1;
  localparam int   BYTE_W = 8;

endpackage

// File: rtl/usb_nrzi_dec.sv
// usb_nrzi_dec: NRZI decoder. It keeps the previous line level and reports
// decoded 1 when the line did not change, 0 when it toggled.
//   clk, rst_n : clock, async active-low reset (prev_line resets to J)
//   en_i       : bit strobe; prev_line only moves when high
//   hold_i     : SE0 on the line; prev_line keeps its value
//   load_j_i   : force prev_line to J (end of packet recovery)
//   line_i     : line level, 1 = J
//   d_o        : decoded bit (combinational, valid while en_i is high)
module usb_nrzi_dec
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic hold_i,
  input  logic load_j_i,
  input  logic line_i,
  output logic d_o
);

  logic prev_q;

  assign d_o = (line_i == prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= LINE_J;
    end else if (en_i) begin
      if (load_j_i)     prev_q <= LINE_J;
      else if (!hold_i) prev_q <= line_i;
    end
  end

endmodule

// File: rtl/usb_rx_bitdec.sv
// usb_rx_bitdec: USB full-speed receive bit-level front end.
// NRZI decode, SYNC detection, bit unstuffing, LSB-first byte assembly,
// EOP detection and error flagging. One line sample is consumed per bit_en.
//   clk, reset : clock, async active-low reset
//   bit_en     : one-clk strobe per bit time, qualifies rx_j / rx_se0
//   rx_j       : line state, 1 = J, 0 = K (ignored during SE0)
//   rx_se0     : single-ended zero on the line
//   rx_active  : high from SYNC end until EOP / error
//   rx_data    : last assembled byte, first received bit in [0]
//   rx_valid   : one-clk pulse, rx_data updated
//   rx_eop     : one-clk pulse on a good EOP (SE0 then J)
//   rx_error   : one-clk pulse on stuff error, partial byte at EOP, bad EOP
module usb_rx_bitdec
  import usb_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 6,
  parameter int STUFF_LEN      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              rx_j,
  input  logic              rx_se0,
  output logic              rx_active,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_eop,
  output logic              rx_error
);

  localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);
  localparam logic [2:0] STUFF_N  = 3'(STUFF_LEN);

  rx_state_t         state_q;
  logic [2:0]        zero_cnt_q;
  logic [2:0]        ones_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [BYTE_W-1:0] shift_sr_q;
  logic              partial_q;
  logic              seen_se0_q;

  logic              d;
  logic              load_j;
  logic [BYTE_W-1:0] shift_d;

  // Leaving EOP/WAIT on a J: re-arm the decoder on idle J.
  assign load_j = !rx_se0 && rx_j &&
                  ((state_q == RX_EOP) || ((state_q == RX_WAIT) && seen_se0_q));

  // New bits enter at the MSB so the first bit ends up in bit 0.
  assign shift_d = {d, shift_sr_q[BYTE_W-1:1]};

  usb_nrzi_dec u_nrzi (
    .clk      (clk),
    .rst_n    (reset),
    .en_i     (bit_en),
    .hold_i   (rx_se0),
    .load_j_i (load_j),
    .line_i   (rx_j),
    .d_o      (d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      zero_cnt_q <= '0;
      ones_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_sr_q <= '0;
      partial_q  <= 1'b0;
      seen_se0_q <= 1'b0;
      rx_active  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_eop     <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      // pulses last exactly one clk regardless of bit_en
      rx_valid <= 1'b0;
      rx_eop   <= 1'b0;
      rx_error <= 1'b0;
      if (bit_en) begin
        unique case (state_q)
          RX_IDLE: begin
            if (!rx_se0) begin
              if (!d) begin
                if (zero_cnt_q != 3'd7) zero_cnt_q <= zero_cnt_q + 3'd1;
              end else begin
                zero_cnt_q <= '0;
                if (zero_cnt_q >= SYNC_MIN) begin
                  state_q    <= RX_DATA;
                  rx_active  <= 1'b1;
                  ones_cnt_q <= 3'd1;  // SYNC's final 1 counts toward stuffing
                  bit_cnt_q  <= '0;
                end
              end
            end
          end
          RX_DATA: begin
            if (rx_se0) begin
              state_q   <= RX_EOP;
              partial_q <= (bit_cnt_q != 3'd0);
            end else if (ones_cnt_q == STUFF_N) begin
              if (d) begin
                rx_error   <= 1'b1;
                rx_active  <= 1'b0;
                seen_se0_q <= 1'b0;
                state_q    <= RX_WAIT;
              end else begin
                ones_cnt_q <= '0;      // stuffed 0, not data
              end
            end else begin
              shift_sr_q <= shift_d;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              ones_cnt_q <= d ? ones_cnt_q + 3'd1 : 3'd0;
              if (bit_cnt_q == 3'd7) begin
                rx_data  <= shift_d;
                rx_valid <= 1'b1;
              end
            end
          end
          RX_EOP: begin
            if (!rx_se0) begin
              rx_active <= 1'b0;
              if (rx_j) begin
                rx_eop   <= 1'b1;
                rx_error <= partial_q;
                state_q  <= RX_IDLE;
              end else begin
                rx_error   <= 1'b1;
                seen_se0_q <= 1'b0;
                state_q    <= RX_WAIT;
              end
            end
          end
          RX_WAIT: begin
            // recover only on a J that follows an SE0 seen while waiting
            if (rx_se0)                 seen_se0_q <= 1'b1;
            else if (rx_j && seen_se0_q) state_q   <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_bitdec.sv
module tb_usb_rx_bitdec;
  import usb_pkg::*;

  localparam int K_NORM = 0, K_PART = 1, K_STUFF = 2, K_BADEOP = 3;

  logic       clk = 1'b0;
  logic       reset, bit_en, rx_j, rx_se0;
  logic       rx_active, rx_valid, rx_eop, rx_error;
  logic [7:0] rx_data;

  int          total = 0, bad = 0;
  logic        lvl;
  logic [10:0] exp_q[$], act_q[$];
  logic [7:0]  pkt_bytes[$];
  bit          bits_q[$];
  int          run_ones;

  always #5 clk = ~clk;

  usb_rx_bitdec dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .rx_j(rx_j), .rx_se0(rx_se0),
    .rx_active(rx_active), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_eop(rx_eop), .rx_error(rx_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // event record: {valid, eop, error, data-if-valid}
  always @(negedge clk)
    if (reset && (rx_valid || rx_eop || rx_error))
      act_q.push_back({rx_valid, rx_eop, rx_error, rx_valid ? rx_data : 8'h00});

  task automatic send_line(input logic se0, input logic j);
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) begin
      @(posedge clk); #1;
      bit_en = 1'b0; rx_j = 1'($urandom); rx_se0 = 1'($urandom);
    end
    @(posedge clk); #1;
    bit_en = 1'b1; rx_j = j; rx_se0 = se0;
  endtask

  task automatic settle();
    @(posedge clk); #1;
    bit_en = 1'b0; rx_se0 = 1'b0; rx_j = 1'b1;
  endtask

  // decoded 0 = transition, 1 = no transition
  task automatic send_dec(input bit b);
    if (!b) lvl = ~lvl;
    send_line(1'b0, lvl);
  endtask

  // transmitter-side stuffing: a 0 after every six consecutive 1s,
  // the SYNC's final 1 already counting as the first
  task automatic stuff_bit(input bit b);
    bits_q.push_back(b);
    run_ones = b ? run_ones + 1 : 0;
    if (run_ones == 6) begin
      bits_q.push_back(1'b0);
      run_ones = 0;
    end
  endtask

  task automatic send_head(input bit drop);
    lvl = 1'b1;
    repeat ($urandom_range(2, 4)) send_line(1'b0, 1'b1);
    repeat (drop ? 6 : 7) send_dec(1'b0);
    settle();
    chk("act_pre_sync", rx_active, 0);
    send_dec(1'b1);
    settle();
    chk("act_sync", rx_active, 1);
    bits_q.delete();
    run_ones = 1;
  endtask

  task automatic send_bits();
    foreach (bits_q[i]) send_dec(bits_q[i]);
  endtask

  task automatic run_pkt(input int kind, input bit drop, input int nextra);
    exp_q.delete();
    act_q.delete();
    send_head(drop);
    foreach (pkt_bytes[i]) begin
      exp_q.push_back({3'b100, pkt_bytes[i]});
      for (int k = 0; k < 8; k++) stuff_bit(pkt_bytes[i][k]);
    end
    if (kind == K_PART)
      for (int k = 0; k < nextra; k++) stuff_bit(1'($urandom));
    if (kind == K_STUFF) begin
      if (pkt_bytes.size() > 0) bits_q.push_back(1'b0);
      repeat (7) bits_q.push_back(1'b1);
    end
    send_bits();
    case (kind)
      K_NORM, K_PART: begin
        repeat ($urandom_range(1, 3)) send_line(1'b1, 1'($urandom));
        lvl = 1'b1; send_line(1'b0, 1'b1);
        exp_q.push_back({2'b01, (kind == K_PART), 8'h00});
      end
      K_STUFF: begin
        exp_q.push_back(11'b001_0000_0000);
        repeat (2) send_line(1'b1, 1'($urandom));
        lvl = 1'b1; send_line(1'b0, 1'b1);
      end
      default: begin
        repeat ($urandom_range(1, 2)) send_line(1'b1, 1'($urandom));
        send_line(1'b0, 1'b0);          // K instead of J after SE0
        exp_q.push_back(11'b001_0000_0000);
        send_line(1'b1, 1'($urandom));
        lvl = 1'b1; send_line(1'b0, 1'b1);
      end
    endcase
    repeat (3) settle();
    chk("n_events", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("event%0d", i), act_q[i], exp_q[i]);
    chk("act_end", rx_active, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; bit_en = 1'b0; rx_j = 1'b1; rx_se0 = 1'b0; lvl = 1'b1;
    #12;
    chk("rst_active", rx_active, 0);
    chk("rst_data",   rx_data,   0);
    chk("rst_valid",  rx_valid,  0);
    chk("rst_eop",    rx_eop,    0);
    chk("rst_error",  rx_error,  0);
    #5 reset = 1'b1;

    // basic packet, full SYNC
    pkt_bytes = '{8'hA5};
    run_pkt(K_NORM, 1'b0, 0);
    // SYNC missing one bit
    pkt_bytes = '{8'h3C};
    run_pkt(K_NORM, 1'b1, 0);
    // stuffing across SYNC's final 1
    pkt_bytes = '{8'hFF, 8'h01};
    run_pkt(K_NORM, 1'b0, 0);
    // seven 1s straight after SYNC, then recovery
    pkt_bytes = '{};
    run_pkt(K_STUFF, 1'b0, 0);
    pkt_bytes = '{8'h96};
    run_pkt(K_NORM, 1'b0, 0);
    // EOP after 3 data bits
    pkt_bytes = '{};
    run_pkt(K_PART, 1'b0, 3);
    // bad EOP
    pkt_bytes = '{8'h11};
    run_pkt(K_BADEOP, 1'b0, 0);

    // async reset in the middle of a byte
    act_q.delete();
    pkt_bytes = '{8'h5A};
    send_head(1'b0);
    for (int k = 0; k < 8; k++) stuff_bit(pkt_bytes[0][k]);
    for (int k = 0; k < 4; k++) stuff_bit(1'($urandom));
    send_bits();
    settle();
    chk("pre_rst_data", rx_data, 8'h5A);
    chk("pre_rst_act",  rx_active, 1);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_active", rx_active, 0);
    chk("mid_rst_data",   rx_data,   0);
    chk("mid_rst_pulses", {rx_valid, rx_eop, rx_error}, 0);
    #13 reset = 1'b1;
    lvl = 1'b1;
    pkt_bytes = '{8'hC3, 8'h7E};
    run_pkt(K_NORM, 1'b0, 0);

    // random packets
    for (int p = 0; p < 40; p++) begin
      int kind, nb;
      kind = $urandom_range(0, 3);
      nb   = $urandom_range(0, 3);
      pkt_bytes.delete();
      for (int i = 0; i < nb; i++)
        pkt_bytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_pkt(kind, 1'($urandom), $urandom_range(1, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
